// File: rtl/xnor_lfsr_gen_pkg.sv
// Shared constants and types for the XNOR LFSR pattern generator.
// Holds maximal-length tap masks for 4..16 bits and the handshake FSM states.
package lfsr_pkg;

    localparam int MIN_WIDTH = 4;
    localparam int MAX_WIDTH = 16;

    // Tap masks use bit (n-1) for polynomial term x^n.
    localparam logic [15:0] TAPS_4  = 16'h000C;
    localparam logic [15:0] TAPS_5  = 16'h0014;
    localparam logic [15:0] TAPS_6  = 16'h0030;
    localparam logic [15:0] TAPS_7  = 16'h0060;
    localparam logic [15:0] TAPS_8  = 16'h00B8;
    localparam logic [15:0] TAPS_9  = 16'h0110;
    localparam logic [15:0] TAPS_10 = 16'h0240;
    localparam logic [15:0] TAPS_11 = 16'h0500;
    localparam logic [15:0] TAPS_12 = 16'h0829;
    localparam logic [15:0] TAPS_13 = 16'h100D;
    localparam logic [15:0] TAPS_14 = 16'h2015;
    localparam logic [15:0] TAPS_15 = 16'h6000;
    localparam logic [15:0] TAPS_16 = 16'hD008;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } fsm_t;

    function automatic logic [15:0] tap_mask(input int width);
        logic [15:0] m;
        m = 16'h0000;
        case (width)
            4:       m = TAPS_4;
            5:       m = TAPS_5;
            6:       m = TAPS_6;
            7:       m = TAPS_7;
            8:       m = TAPS_8;
            9:       m = TAPS_9;
            10:      m = TAPS_10;
            11:      m = TAPS_11;
            12:      m = TAPS_12;
            13:      m = TAPS_13;
            14:      m = TAPS_14;
            15:      m = TAPS_15;
            16:      m = TAPS_16;
            default: m = 16'h0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/xnor_lfsr_gen_step.sv
// Combinational next-state function of a Fibonacci LFSR with XNOR feedback.
// Ports: cur (present state) -> nxt (state after one advance).
module lfsr_xnor_step
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(tap_mask(WIDTH))
) (
    input  logic [WIDTH-1:0] cur,
    output logic [WIDTH-1:0] nxt
);

    logic fb;

    // XNOR feedback maps all-ones onto itself, so no advance ever enters it.
    assign fb  = ~^(cur & TAPS);
    assign nxt = {cur[WIDTH-2:0], fb};

endmodule

// File: rtl/xnor_lfsr_gen.sv
// Pseudo-random a/b stimulus source with valid/ready output handshake.
// Ports: clk, rst (async high), en, load, seed, out_ready in;
//        out_valid, a, b, state, period_done, lockup out.
module xnor_lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] TAPS    = WIDTH'(tap_mask(WIDTH)),
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             out_ready,
    output logic             out_valid,
    output logic             a,
    output logic             b,
    output logic [WIDTH-1:0] state,
    output logic             period_done,
    output logic             lockup
);

    localparam logic [WIDTH-1:0] ONES = '1;
    localparam logic [WIDTH-1:0] WRAP = WIDTH'((1 << WIDTH) - 2);

    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] start_q;
    logic [WIDTH-1:0] step_q;
    logic             adv;
    logic             seed_bad;
    logic             last_step;
    logic             stall_cond;
    fsm_t             fsm_q;
    fsm_t             fsm_d;

    lfsr_xnor_step #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_step (
        .cur (state),
        .nxt (nxt)
    );

    assign a          = state[0];
    assign b          = state[1];
    assign adv        = en & ~load & (~out_valid | out_ready);
    assign seed_bad   = (seed == ONES);
    assign last_step  = (step_q == WRAP);
    assign stall_cond = out_valid & ~out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RST_VAL;
            start_q     <= RST_VAL;
            step_q      <= '0;
            out_valid   <= 1'b0;
            period_done <= 1'b0;
            lockup      <= 1'b0;
        end else begin
            period_done <= 1'b0;
            lockup      <= 1'b0;
            if (load) begin
                out_valid <= 1'b0;
                step_q    <= '0;
                if (seed_bad) begin
                    state   <= RST_VAL;
                    start_q <= RST_VAL;
                    lockup  <= 1'b1;
                end else begin
                    state   <= seed;
                    start_q <= seed;
                end
            end else if (adv) begin
                state     <= nxt;
                out_valid <= 1'b1;
                if (last_step) begin
                    step_q      <= '0;
                    // Both agree for a maximal tap set; the compare guards bad masks.
                    period_done <= (nxt == start_q);
                end else begin
                    step_q <= step_q + WIDTH'(1);
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q <= IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        if (load) begin
            fsm_d = IDLE;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (en) fsm_d = RUN;
                end
                RUN: begin
                    // A pending pattern outlives en until it is taken.
                    if (stall_cond)
                        fsm_d = STALL;
                    else if (!en)
                        fsm_d = IDLE;
                end
                STALL: begin
                    if (out_ready)
                        fsm_d = en ? RUN : IDLE;
                end
                default: fsm_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xnor_lfsr_gen.sv
// Self-checking bench for xnor_lfsr_gen (WIDTH=8, TAPS=8'hB8).
// Reference model: tap parity counting plus plain handshake bookkeeping.
module tb_xnor_lfsr_gen;
    import lfsr_pkg::*;

    localparam logic [7:0] TAPS_REF = 8'hB8;

    logic       clk;
    logic       rst;
    logic       en;
    logic       load;
    logic [7:0] seed;
    logic       out_ready;
    logic       out_valid;
    logic       a;
    logic       b;
    logic [7:0] state;
    logic       period_done;
    logic       lockup;

    int checks;
    int errors;

    logic [7:0] m_state;
    logic [7:0] m_start;
    logic       m_valid;
    logic       m_pd;
    logic       m_lock;

    xnor_lfsr_gen dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .load        (load),
        .seed        (seed),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .a           (a),
        .b           (b),
        .state       (state),
        .period_done (period_done),
        .lockup      (lockup)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not end, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    // Feedback bit is 1 when an even number of tapped bits are set.
    function automatic logic [7:0] ref_next(input logic [7:0] s);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++)
            if (s[i] && TAPS_REF[i]) ones++;
        return {s[6:0], ((ones % 2) == 0)};
    endfunction

    task automatic model_reset();
        m_state = 8'h00;
        m_start = 8'h00;
        m_valid = 1'b0;
        m_pd    = 1'b0;
        m_lock  = 1'b0;
    endtask

    task automatic model_edge();
        logic       go;
        logic [7:0] n;
        m_pd   = 1'b0;
        m_lock = 1'b0;
        if (load) begin
            m_valid = 1'b0;
            if (seed == 8'hFF) begin
                m_lock  = 1'b1;
                m_state = 8'h00;
            end else begin
                m_state = seed;
            end
            m_start = m_state;
        end else begin
            go = en && (!m_valid || out_ready);
            if (go) begin
                n       = ref_next(m_state);
                m_pd    = (n == m_start);
                m_state = n;
                m_valid = 1'b1;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; load = 1'b0; out_ready = 1'b0; seed = 8'h00;
        tick(); tick();
        checks++;
        if (state !== 8'h00) begin
            errors++; $display("FAIL reset_state: got %h want 00", state);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid: got %b want 0", out_valid);
        end
        checks++;
        if (period_done !== 1'b0 || lockup !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulses: pd=%b lock=%b want 0/0", period_done, lockup);
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_sequence();
        logic [7:0] exp_seq [6];
        exp_seq = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1E, 8'h3D};
        en = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (state !== exp_seq[i] || state !== m_state) begin
                errors++;
                $display("FAIL seq_state[%0d]: got %h want %h", i, state, exp_seq[i]);
            end
            checks++;
            if (out_valid !== 1'b1) begin
                errors++; $display("FAIL seq_valid[%0d]: got %b want 1", i, out_valid);
            end
            if (i == 0) begin
                checks++;
                if (a !== 1'b1 || b !== 1'b0) begin
                    errors++; $display("FAIL seq_ab: got a=%b b=%b want 1/0", a, b);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [7:0] held;
        held = state;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (state !== held || a !== held[0] || b !== held[1]) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got %h want %h", i, state, held);
            end
            checks++;
            if (out_valid !== 1'b1) begin
                errors++; $display("FAIL stall_valid[%0d]: got %b want 1", i, out_valid);
            end
            checks++;
            if (dut.fsm_q !== STALL) begin
                errors++; $display("FAIL stall_fsm[%0d]: got %0d want STALL", i, dut.fsm_q);
            end
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (state !== ref_next(held) || state !== m_state) begin
            errors++;
            $display("FAIL stall_resume: got %h want %h", state, ref_next(held));
        end
    endtask

    task automatic test_load();
        en = 1'b0; load = 1'b1; seed = 8'hFF;
        tick();
        checks++;
        if (state !== 8'h00 || lockup !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL load_ff: state=%h lock=%b valid=%b want 00/1/0",
                     state, lockup, out_valid);
        end
        load = 1'b0;
        tick();
        checks++;
        if (lockup !== 1'b0 || state !== 8'h00) begin
            errors++;
            $display("FAIL load_ff_after: lock=%b state=%h want 0/00", lockup, state);
        end
        load = 1'b1; seed = 8'h5A;
        tick();
        checks++;
        if (state !== 8'h5A || out_valid !== 1'b0 || lockup !== 1'b0) begin
            errors++;
            $display("FAIL load_5a: state=%h valid=%b lock=%b want 5A/0/0",
                     state, out_valid, lockup);
        end
        load = 1'b0;
        tick();
        checks++;
        if (state !== m_state || lockup !== 1'b0) begin
            errors++; $display("FAIL load_hold: state=%h want %h", state, m_state);
        end
    endtask

    task automatic test_load_in_stall();
        logic [7:0] s;
        en = 1'b1; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick(); tick();
        checks++;
        if (dut.fsm_q !== STALL || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL lstall_pre: fsm=%0d valid=%b want STALL/1", dut.fsm_q, out_valid);
        end
        s = 8'($urandom_range(0, 254));
        load = 1'b1; out_ready = 1'b1; seed = s;
        tick();
        checks++;
        if (state !== s || out_valid !== 1'b0 || lockup !== 1'b0) begin
            errors++;
            $display("FAIL lstall_load: state=%h valid=%b want %h/0", state, out_valid, s);
        end
        load = 1'b0; out_ready = 1'b0; en = 1'b0;
        tick();
        checks++;
        if (state !== s || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL lstall_drop: state=%h valid=%b want %h/0", state, out_valid, s);
        end
    endtask

    task automatic test_period();
        int  adv_cnt;
        int  pd_cnt;
        int  cyc;
        bit  go;
        bit  seen [256];
        rst = 1'b1; load = 1'b0; en = 1'b0; out_ready = 1'b0;
        tick();
        rst = 1'b0;
        model_reset();
        en = 1'b1;
        adv_cnt = 0; pd_cnt = 0; cyc = 0;
        foreach (seen[i]) seen[i] = 1'b0;
        seen[0] = 1'b1;
        while (adv_cnt < 255 && cyc < 3000) begin
            out_ready = ($urandom_range(0, 3) != 0);
            go = en && (!m_valid || out_ready);
            tick();
            cyc++;
            if (go) begin
                adv_cnt++;
                if (adv_cnt < 255) begin
                    checks++;
                    if (seen[state]) begin
                        errors++;
                        $display("FAIL period_repeat: %h revisited at adv %0d", state, adv_cnt);
                    end
                    seen[state] = 1'b1;
                end
            end
            checks++;
            if (state !== m_state || out_valid !== m_valid) begin
                errors++;
                $display("FAIL period_track: state=%h valid=%b want %h/%b",
                         state, out_valid, m_state, m_valid);
            end
            checks++;
            if (state === 8'hFF) begin
                errors++; $display("FAIL period_ff: lock-up state reached");
            end
            checks++;
            if (period_done !== m_pd) begin
                errors++;
                $display("FAIL period_pulse: got %b want %b at adv %0d",
                         period_done, m_pd, adv_cnt);
            end
            if (period_done === 1'b1) pd_cnt++;
        end
        checks++;
        if (adv_cnt != 255) begin
            errors++; $display("FAIL period_budget: only %0d advances", adv_cnt);
        end
        checks++;
        if (pd_cnt != 1 || state !== 8'h00 || period_done !== 1'b1) begin
            errors++;
            $display("FAIL period_end: pulses=%0d state=%h pd=%b want 1/00/1",
                     pd_cnt, state, period_done);
        end
    endtask

    task automatic test_async_reset();
        en = 1'b1; out_ready = 1'b1; load = 1'b0;
        repeat (3) tick();
        @(posedge clk);
        model_edge();
        #3 rst = 1'b1;
        #1;
        checks++;
        if (state !== 8'h00 || out_valid !== 1'b0 || a !== 1'b0 || b !== 1'b0) begin
            errors++;
            $display("FAIL async_rst: state=%h valid=%b want 00/0", state, out_valid);
        end
        checks++;
        if (period_done !== 1'b0 || lockup !== 1'b0) begin
            errors++;
            $display("FAIL async_rst_pulse: pd=%b lock=%b want 0/0", period_done, lockup);
        end
        model_reset();
        #3 rst = 1'b0;
        tick();
        checks++;
        if (state !== 8'h01 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL async_restart: state=%h valid=%b want 01/1", state, out_valid);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            en        = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 1) != 0);
            load      = ($urandom_range(0, 15) == 0);
            seed      = ($urandom_range(0, 5) == 0) ? 8'hFF : 8'($urandom);
            tick();
            checks++;
            if (state !== m_state || a !== m_state[0] || b !== m_state[1]) begin
                errors++;
                $display("FAIL rand_state[%0d]: got %h want %h", i, state, m_state);
            end
            checks++;
            if (out_valid !== m_valid) begin
                errors++;
                $display("FAIL rand_valid[%0d]: got %b want %b", i, out_valid, m_valid);
            end
            checks++;
            if (lockup !== m_lock || period_done !== m_pd) begin
                errors++;
                $display("FAIL rand_pulse[%0d]: lock=%b pd=%b want %b/%b",
                         i, lockup, period_done, m_lock, m_pd);
            end
        end
        load = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; en = 1'b0; load = 1'b0; seed = 8'h00; out_ready = 1'b0;
        model_reset();
        test_reset();
        test_sequence();
        test_stall();
        test_load();
        test_load_in_stall();
        test_period();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
